// File: rtl/sync_ram_arbiter_pkg.sv
// Shared constants and types for the sync_ram round-robin arbiter.
// RAM geometry defaults and read latency are also used by sync_ram and its bench.
package sync_ram_arbiter_pkg;

    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned RamRdLat = 1;
    localparam int unsigned MinReq   = 2;
    localparam int unsigned MaxReq   = 8;

    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } op_e;

endpackage

// File: rtl/sync_ram_arbiter_rr.sv
// Round-robin grant logic: lowest requesting index at or above the pointer wins, wrapping.
// The pointer moves to one past the winner on every accepted command.
module sync_ram_arbiter_rr #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx,
    output logic                       o_gnt_vld
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Extra bit on the candidate lets ptr+i exceed NUM_REQ-1 before the explicit wrap.
    always_comb begin
        logic [IDX_W:0] v_cand;
        w_found = 1'b0;
        w_idx   = '0;
        v_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            v_cand = {1'b0, r_ptr} + (IDX_W + 1)'(i);
            if (v_cand >= NumReqW) begin
                v_cand = v_cand - NumReqW;
            end
            if (!w_found && i_req[v_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = v_cand[IDX_W-1:0];
            end
        end
    end

    // Grant is forced low while reset is asserted even though requests may be active.
    always_comb begin
        o_gnt = '0;
        if (w_found && rst_n) begin
            o_gnt[w_idx] = 1'b1;
        end
    end

    assign o_gnt_idx = w_idx;
    assign o_gnt_vld = w_found & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == LastIdx) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sync_ram_arbiter.sv
// Shares one single-port sync_ram among NUM_REQ requesters: registers the winning command onto
// the RAM port and returns read data to its owner with a one-cycle rvalid strobe.
module sync_ram_arbiter
    import sync_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    input  logic [DATA_W-1:0]         ram_dout
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_accept;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    op_e                w_op;
    logic [NUM_REQ-1:0] w_issue_oh;

    logic               r_ram_en;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic [IDX_W-1:0]   r_issue_owner;
    logic               r_issue_rd;
    logic [NUM_REQ-1:0] r_rvalid;

    sync_ram_arbiter_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req),
        .o_gnt     (gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_accept)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_op = w_sel_we ? OpWrite : OpRead;

    // Issue stage: address and write data hold when idle; only en/we drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
            r_issue_owner <= '0;
            r_issue_rd    <= 1'b0;
        end else if (w_accept) begin
            r_ram_en      <= 1'b1;
            r_ram_we      <= (w_op == OpWrite);
            r_ram_addr    <= w_sel_addr;
            r_ram_din     <= w_sel_wdata;
            r_issue_owner <= w_gnt_idx;
            r_issue_rd    <= (w_op == OpRead);
        end else begin
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_issue_rd    <= 1'b0;
        end
    end

    always_comb begin
        w_issue_oh = '0;
        w_issue_oh[r_issue_owner] = r_issue_rd;
    end

    // Response stage lines up with the RAM sampling the issued read, so dout is valid with rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_issue_oh;
        end
    end

    assign ram_en   = r_ram_en;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign rvalid   = r_rvalid;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Directed bench for sync_ram_arbiter with a behavioural sync_ram behind it (NUM_REQ=2).
module tb_sync_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] req_we;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata;
    logic       ram_en;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [7:0] mem [16];

    int n_checks;
    int n_err;
    logic m_ptr;

    sync_ram_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (4),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  ({a1, a0}),
        .req_wdata ({d1, d0}),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port sync RAM, contents not reset.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic [1:0] rv;
        logic       en;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_gnt(input logic [1:0] r, input logic p);
        logic [1:0] g;
        g = 2'b00;
        if (r[p])       g[p] = 1'b1;
        else if (r[!p]) g[!p] = 1'b1;
        return g;
    endfunction

    initial begin
        n_checks = 0;
        n_err    = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        ram_dout = 8'h00;

        //             req    we     a0    a1    d0     d1     gnt    rv     en    rd
        vecs[0]  = '{2'b01, 2'b01, 4'd1, 4'd0, 8'hA5, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00};
        vecs[1]  = '{2'b01, 2'b01, 4'd2, 4'd0, 8'h3C, 8'h00, 2'b01, 2'b00, 1'b1, 8'h00};
        vecs[2]  = '{2'b01, 2'b01, 4'd3, 4'd0, 8'h7F, 8'h00, 2'b01, 2'b00, 1'b1, 8'h00};
        vecs[3]  = '{2'b01, 2'b00, 4'd1, 4'd0, 8'h00, 8'h00, 2'b01, 2'b00, 1'b1, 8'h00};
        vecs[4]  = '{2'b01, 2'b00, 4'd2, 4'd0, 8'h00, 8'h00, 2'b01, 2'b00, 1'b1, 8'h00};
        vecs[5]  = '{2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 2'b01, 1'b1, 8'hA5};
        vecs[6]  = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b01, 1'b1, 8'h3C};
        vecs[7]  = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b01, 1'b0, 8'h7F};
        vecs[8]  = '{2'b10, 2'b10, 4'd0, 4'd4, 8'h00, 8'h44, 2'b10, 2'b00, 1'b0, 8'h00};
        vecs[9]  = '{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 2'b00, 1'b1, 8'h00};
        vecs[10] = '{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 2'b00, 1'b1, 8'h00};
        vecs[11] = '{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01, 2'b01, 1'b1, 8'hA5};
        vecs[12] = '{2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b10, 2'b10, 1'b1, 8'h3C};
        vecs[13] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b01, 1'b1, 8'hA5};
        vecs[14] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b10, 1'b0, 8'h3C};
        vecs[15] = '{2'b01, 2'b01, 4'd5, 4'd0, 8'h5A, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00};
        vecs[16] = '{2'b10, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00, 2'b10, 2'b00, 1'b1, 8'h00};
        vecs[17] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h00};
        vecs[18] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b10, 1'b0, 8'h5A};
        vecs[19] = '{2'b10, 2'b00, 4'd0, 4'd4, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0, 8'h00};
        vecs[20] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 8'h00};
        vecs[21] = '{2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 2'b10, 1'b0, 8'h44};

        // Reset with both requesting.
        rst_n  = 1'b0;
        req    = 2'b11;
        req_we = 2'b00;
        a0 = 4'd0; a1 = 4'd0; d0 = 8'h00; d1 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {6'd0, gnt}, 8'h00);
        check("rst_rvalid", {6'd0, rvalid}, 8'h00);
        check("rst_ram_en", {7'd0, ram_en}, 8'h00);
        check("rst_ram_addr", {4'd0, ram_addr}, 8'h00);
        rst_n = 1'b1;
        #1;
        check("first_gnt", {6'd0, gnt}, 8'h01);
        req = 2'b00;

        // Single master, contention, write-then-read hazard.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            req    = vecs[i].req;
            req_we = vecs[i].we;
            a0     = vecs[i].a0;
            a1     = vecs[i].a1;
            d0     = vecs[i].d0;
            d1     = vecs[i].d1;
            @(negedge clk);
            check($sformatf("v%0d_gnt", i), {6'd0, gnt}, {6'd0, vecs[i].gnt});
            check($sformatf("v%0d_rvalid", i), {6'd0, rvalid}, {6'd0, vecs[i].rv});
            check($sformatf("v%0d_ram_en", i), {7'd0, ram_en}, {7'd0, vecs[i].en});
            if (vecs[i].rv != 2'b00) begin
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
            end
        end

        // Reset one cycle after a read accept.
        @(posedge clk);
        #1;
        req = 2'b01; req_we = 2'b00; a0 = 4'd1;
        @(negedge clk);
        check("mid_gnt", {6'd0, gnt}, 8'h01);
        @(posedge clk);
        #1;
        req = 2'b00;
        @(negedge clk);
        check("mid_issue_en", {7'd0, ram_en}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_async_en", {7'd0, ram_en}, 8'h00);
        check("mid_async_rvalid", {6'd0, rvalid}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_rvalid%0d", i), {6'd0, rvalid}, 8'h00);
        end
        @(posedge clk);
        #1;
        req = 2'b11; req_we = 2'b00; a0 = 4'd1; a1 = 4'd2;
        #1;
        check("post_rst_ptr_gnt", {6'd0, gnt}, 8'h01);
        req = 2'b01;
        @(posedge clk);
        #1;
        req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_rvalid", {6'd0, rvalid}, 8'h01);
        check("post_rst_rdata", rdata, 8'hA5);
        m_ptr = 1'b1;

        // Idle gaps: requests raised then dropped before the edge.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            req    = 2'($urandom_range(0, 3));
            req_we = 2'($urandom_range(0, 3));
            a0     = 4'($urandom_range(0, 15));
            a1     = 4'($urandom_range(0, 15));
            @(negedge clk);
            check($sformatf("idle%0d_gnt", i), {6'd0, gnt}, {6'd0, exp_gnt(req, m_ptr)});
            check($sformatf("idle%0d_ram_en", i), {7'd0, ram_en}, 8'h00);
            check($sformatf("idle%0d_rvalid", i), {6'd0, rvalid}, 8'h00);
            #1;
            req = 2'b00;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
